reg_bus_arb: RTL

//  Shares the single internal register bus (ren/wen/addr/wdata, OR-combined rdata from all

---
 rtl/reg_bus_pkg.sv | 14 +
 rtl/reg_bus_arb_rr.sv | 36 +++
 rtl/reg_bus_arb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types for the internal register bus: bus FSM states and the
// read-data value returned for writes and refused accesses.
package reg_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } bus_st_e;

   // Read data returned on writes and refused accesses (sliced to DW by users).
   localparam logic [63:0] RD_ZERO = 64'd0;

endpackage

// File: rtl/reg_bus_arb_rr.sv
// Combinational round-robin picker: the first requester after ptr (wrapping
// at NREQ) wins. Outputs a one-hot grant, its index, and an any-request flag.
module rr_arb #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int          sum;
   logic [IW-1:0] cand;

   // Scan from ptr+1 upward (wrapping) and keep the first requester found.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = 0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         sum = int'(ptr) + k;
         if (sum >= NREQ) sum = sum - NREQ;
         cand = IW'(sum);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/reg_bus_arb.sv
// Register bus arbiter: shares one ren/wen/addr/wdata bus between NREQ
// requesters with round-robin arbitration, one access per grant, mode-based
// access gating and a fully registered response.
//
// Requester handshake: a requester raises i_req[k] with stable wr/addr/wdata
// and holds it until it sees o_ack[k] (a single-cycle pulse, qualified by
// o_err/o_rdata). It must drop i_req[k] in the cycle after o_ack; a request
// still high then is treated as a new request. Non-granted requesters simply
// keep i_req high and are served in turn.
module reg_bus_arb
   import reg_bus_pkg::*;
#(
   parameter int DW   = 8,
   parameter int AW   = 8,
   parameter int NREQ = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [NREQ-1:0]  i_req,
   input  logic [NREQ-1:0]  i_req_wr,
   input  logic [NREQ*AW-1:0] i_req_addr,
   input  logic [NREQ*DW-1:0] i_req_wdata,
   output logic [NREQ-1:0]  o_ack,
   output logic             o_err,
   output logic [DW-1:0]    o_rdata,
   output logic             o_busy,
   input  logic             i_test_mode_status,
   input  logic             i_cfg_mode_status,
   output logic             o_ren,
   output logic             o_wen,
   output logic [AW-1:0]    o_addr,
   output logic [DW-1:0]    o_wdata,
   input  logic [DW-1:0]    i_rdata,
   output bus_st_e          o_state
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   bus_st_e       state_q, nxt_state;
   logic [IW-1:0] ptr_q, nxt_ptr;
   logic [IW-1:0] idx_q, nxt_idx;
   logic          wr_q, nxt_wr;

   logic          nxt_ren, nxt_wen, nxt_err;
   logic [AW-1:0] nxt_addr;
   logic [DW-1:0] nxt_wdata, nxt_rdata;
   logic [NREQ-1:0] nxt_ack;

   logic [NREQ-1:0] grant;
   logic [IW-1:0]   gidx;
   logic            any_req;
   logic            sel_wr;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic            permit;

   rr_arb #(.NREQ(NREQ), .IW(IW)) u_rr_arb (
      .req   (i_req),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (gidx),
      .any   (any_req)
   );

   // Fields of the requester currently winning arbitration.
   assign sel_wr    = i_req_wr[gidx];
   assign sel_addr  = i_req_addr[int'(gidx)*AW +: AW];
   assign sel_wdata = i_req_wdata[int'(gidx)*DW +: DW];

   // Reads need test or config mode; writes need config mode.
   assign permit = sel_wr ? i_cfg_mode_status
                          : (i_test_mode_status | i_cfg_mode_status);

   assign o_state = state_q;

   // Next state and next registered outputs; every output defaults to idle values.
   always_comb begin
      nxt_state = state_q;
      nxt_ptr   = ptr_q;
      nxt_idx   = idx_q;
      nxt_wr    = wr_q;
      nxt_ren   = 1'b0;
      nxt_wen   = 1'b0;
      nxt_addr  = '0;
      nxt_wdata = '0;
      nxt_ack   = '0;
      nxt_err   = 1'b0;
      nxt_rdata = RD_ZERO[DW-1:0];
      case (state_q)
         IDLE: begin
            if (any_req) begin
               nxt_idx = gidx;
               nxt_wr  = sel_wr;
               nxt_ptr = gidx;
               if (permit) begin
                  nxt_state = ACCESS;
                  nxt_ren   = !sel_wr;
                  nxt_wen   = sel_wr;
                  nxt_addr  = sel_addr;
                  nxt_wdata = sel_wdata;
               end else begin
                  // Refused: skip the bus entirely and answer with an error.
                  nxt_state = RESP;
                  nxt_ack   = grant;
                  nxt_err   = 1'b1;
               end
            end
         end
         ACCESS: begin
            nxt_state      = RESP;
            nxt_ack[idx_q] = 1'b1;
            if (!wr_q) nxt_rdata = i_rdata;
         end
         RESP: begin
            nxt_state = IDLE;
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   // State, grant bookkeeping and registered bus/response outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(NREQ - 1);
         idx_q   <= '0;
         wr_q    <= 1'b0;
         o_ren   <= 1'b0;
         o_wen   <= 1'b0;
         o_addr  <= '0;
         o_wdata <= '0;
         o_ack   <= '0;
         o_err   <= 1'b0;
         o_rdata <= '0;
         o_busy  <= 1'b0;
      end else begin
         state_q <= nxt_state;
         ptr_q   <= nxt_ptr;
         idx_q   <= nxt_idx;
         wr_q    <= nxt_wr;
         o_ren   <= nxt_ren;
         o_wen   <= nxt_wen;
         o_addr  <= nxt_addr;
         o_wdata <= nxt_wdata;
         o_ack   <= nxt_ack;
         o_err   <= nxt_err;
         o_rdata <= nxt_rdata;
         o_busy  <= (nxt_state != IDLE);
      end
   end

endmodule
